ex_mem_stage: RTL and testbench

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

---
 rtl/core_pkg.sv | 31 +++
 rtl/lsu_align.sv | 51 +++++
 rtl/ex_mem_stage.sv | 166 ++++++++++++++++
 tb/tb_ex_mem_stage.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: datapath width, MEM-stage FSM states, load/store
// funct3 encodings and the alignment rule used by the load/store path.
package core_pkg;

   localparam int XLEN = 32;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } mem_state_e;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] SB  = 3'b000;
   localparam logic [2:0] SH  = 3'b001;
   localparam logic [2:0] SW  = 3'b010;

   // funct3[1:0] encodes the access size: 00 byte, 01 half, 10 word.
   function automatic logic is_misaligned(input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
      case (funct3[1:0])
         2'b01:   return addr_lo[0];
         2'b10:   return (addr_lo != 2'b00);
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Load/store lane handling: byte enables, store-data replication, load lane
// select with sign/zero extension, and misalignment detection.
module lsu_align #(
   parameter int XLEN = core_pkg::XLEN
) (
   input  logic [2:0]      funct3,
   input  logic [1:0]      addr_lo,
   input  logic [XLEN-1:0] store_data,
   input  logic [XLEN-1:0] rdata,
   output logic [3:0]      be,
   output logic [XLEN-1:0] wdata,
   output logic [XLEN-1:0] load_data,
   output logic            misaligned
);
   import core_pkg::*;

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   // Lane select and extension for loads; enables and replication for stores.
   always_comb begin
      byte_lane = rdata[{addr_lo, 3'b000} +: 8];
      half_lane = rdata[{addr_lo[1], 4'b0000} +: 16];

      load_data = '0;
      case (funct3)
         LB:      load_data = {{(XLEN-8){byte_lane[7]}}, byte_lane};
         LH:      load_data = {{(XLEN-16){half_lane[15]}}, half_lane};
         LBU:     load_data[7:0] = byte_lane;
         LHU:     load_data[15:0] = half_lane;
         default: load_data = rdata;
      endcase

      be    = 4'b1111;
      wdata = '0;
      case (funct3)
         SB: begin
            be          = 4'b0001 << addr_lo;
            wdata[31:0] = {4{store_data[7:0]}};
         end
         SH: begin
            be          = 4'b0011 << {addr_lo[1], 1'b0};
            wdata[31:0] = {2{store_data[15:0]}};
         end
         default: wdata = store_data;
      endcase

      misaligned = is_misaligned(funct3, addr_lo);
   end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with a blocking data-memory handshake.
// Optional macro EX_MEM_PERF_EN adds a 32-bit stall_cycles counter output.
//
// state  | meaning
// S_IDLE | no access outstanding; stage advances every cycle
// S_WAIT | load/store presented on dmem, waiting for dmem_ack
module ex_mem_stage #(
   parameter int XLEN = core_pkg::XLEN
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ex_valid,
   input  logic [XLEN-1:0] ex_alu_result,
   input  logic [XLEN-1:0] ex_store_data,
   input  logic [4:0]      ex_rd,
   input  logic            ex_reg_write,
   input  logic            ex_mem_read,
   input  logic            ex_mem_write,
   input  logic [2:0]      ex_funct3,
   input  logic            flush,
   output logic            stall_o,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   output logic [3:0]      dmem_be,
   input  logic [XLEN-1:0] dmem_rdata,
   input  logic            dmem_ack,
   output logic [4:0]      rd_mem,
   output logic            reg_write_mem,
   output logic [XLEN-1:0] alu_result_mem,
   output logic [XLEN-1:0] load_data_mem,
   output logic            mem_to_reg_mem,
   output logic            misalign_o
`ifdef EX_MEM_PERF_EN
   ,
   output logic [31:0]     stall_cycles
`endif
);
   import core_pkg::*;

   mem_state_e      state_q, state_d;
   logic            valid_q, valid_d;
   logic [XLEN-1:0] alu_result_q, alu_result_d;
   logic [XLEN-1:0] store_data_q, store_data_d;
   logic [4:0]      rd_q, rd_d;
   logic            reg_write_q, reg_write_d;
   logic            mem_read_q, mem_read_d;
   logic            mem_write_q, mem_write_d;
   logic [2:0]      funct3_q, funct3_d;
   logic [XLEN-1:0] load_data_q, load_data_d;

   logic [3:0]      be_raw;
   logic [XLEN-1:0] wdata_raw;
   logic [XLEN-1:0] load_aligned;
   logic            misaligned_raw;
   logic            mem_op;
   logic            start_access;

   lsu_align #(.XLEN(XLEN)) u_lsu_align (
      .funct3     (funct3_q),
      .addr_lo    (alu_result_q[1:0]),
      .store_data (store_data_q),
      .rdata      (dmem_rdata),
      .be         (be_raw),
      .wdata      (wdata_raw),
      .load_data  (load_aligned),
      .misaligned (misaligned_raw)
   );

   // Handshake and result outputs decoded from the registered bundle.
   always_comb begin
      mem_op         = valid_q & (mem_read_q | mem_write_q);
      dmem_req       = (state_q == S_WAIT);
      stall_o        = (state_q == S_WAIT) & ~dmem_ack;
      dmem_we        = dmem_req & mem_write_q;
      dmem_be        = dmem_req ? be_raw : 4'b0000;
      dmem_addr      = {alu_result_q[XLEN-1:2], 2'b00};
      dmem_wdata     = wdata_raw;
      misalign_o     = mem_op & misaligned_raw;
      reg_write_mem  = valid_q & reg_write_q & ~mem_read_q & ~(mem_op & misaligned_raw);
      mem_to_reg_mem = valid_q & mem_read_q;
      rd_mem         = rd_q;
      alu_result_mem = alu_result_q;
      load_data_mem  = load_data_q;
   end

   // Next-state: capture the EX bundle whenever not stalled, latch load data on ack.
   always_comb begin
      state_d      = state_q;
      valid_d      = valid_q;
      alu_result_d = alu_result_q;
      store_data_d = store_data_q;
      rd_d         = rd_q;
      reg_write_d  = reg_write_q;
      mem_read_d   = mem_read_q;
      mem_write_d  = mem_write_q;
      funct3_d     = funct3_q;
      load_data_d  = load_data_q;

      start_access = ex_valid & ~flush & (ex_mem_read | ex_mem_write) &
                     ~is_misaligned(ex_funct3, ex_alu_result[1:0]);

      if ((state_q == S_WAIT) && dmem_ack) begin
         load_data_d = load_aligned;
      end

      if (!stall_o) begin
         valid_d      = ex_valid & ~flush;
         alu_result_d = ex_alu_result;
         store_data_d = ex_store_data;
         rd_d         = ex_rd;
         reg_write_d  = ex_reg_write;
         mem_read_d   = ex_mem_read;
         mem_write_d  = ex_mem_write;
         funct3_d     = ex_funct3;
         state_d      = start_access ? S_WAIT : S_IDLE;
      end
   end

   // Pipeline and FSM state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         valid_q      <= 1'b0;
         alu_result_q <= '0;
         store_data_q <= '0;
         rd_q         <= '0;
         reg_write_q  <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         funct3_q     <= '0;
         load_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         valid_q      <= valid_d;
         alu_result_q <= alu_result_d;
         store_data_q <= store_data_d;
         rd_q         <= rd_d;
         reg_write_q  <= reg_write_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         funct3_q     <= funct3_d;
         load_data_q  <= load_data_d;
      end
   end

`ifdef EX_MEM_PERF_EN
   logic [31:0] stall_cycles_q, stall_cycles_d;

   // Free-running count of stalled cycles, wrapping naturally at 2^32.
   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (stall_o) stall_cycles_d = stall_cycles_q + 32'd1;
   end

   // Stall counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stall_cycles_q <= '0;
      else        stall_cycles_q <= stall_cycles_d;
   end

   assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: stimulus pushes cycle-tagged expectations,
// a negedge monitor pops and compares them.
module tb_ex_mem_stage;

   localparam int S_STALL = 0, S_REQ = 1, S_WE = 2, S_ADDR = 3, S_WDATA = 4,
                  S_BE = 5, S_RD = 6, S_RWM = 7, S_ALU = 8, S_LOAD = 9,
                  S_M2R = 10, S_MIS = 11, S_PERF = 12;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, flush;
   logic [31:0] ex_alu_result, ex_store_data;
   logic [4:0]  ex_rd;
   logic [2:0]  ex_funct3;
   logic        stall_o, dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic [4:0]  rd_mem;
   logic        reg_write_mem, mem_to_reg_mem, misalign_o;
   logic [31:0] alu_result_mem, load_data_mem;
`ifdef EX_MEM_PERF_EN
   logic [31:0] stall_cycles;
`endif

   typedef struct {
      int          cyc;
      int          sel;
      logic [31:0] exp;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   ex_mem_stage #(.XLEN(32)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ex_valid       (ex_valid),
      .ex_alu_result  (ex_alu_result),
      .ex_store_data  (ex_store_data),
      .ex_rd          (ex_rd),
      .ex_reg_write   (ex_reg_write),
      .ex_mem_read    (ex_mem_read),
      .ex_mem_write   (ex_mem_write),
      .ex_funct3      (ex_funct3),
      .flush          (flush),
      .stall_o        (stall_o),
      .dmem_req       (dmem_req),
      .dmem_we        (dmem_we),
      .dmem_addr      (dmem_addr),
      .dmem_wdata     (dmem_wdata),
      .dmem_be        (dmem_be),
      .dmem_rdata     (dmem_rdata),
      .dmem_ack       (dmem_ack),
      .rd_mem         (rd_mem),
      .reg_write_mem  (reg_write_mem),
      .alu_result_mem (alu_result_mem),
      .load_data_mem  (load_data_mem),
      .mem_to_reg_mem (mem_to_reg_mem),
      .misalign_o     (misalign_o)
`ifdef EX_MEM_PERF_EN
      ,
      .stall_cycles   (stall_cycles)
`endif
   );

   function automatic logic [31:0] get_sig(input int sel);
      case (sel)
         S_STALL: return {31'd0, stall_o};
         S_REQ:   return {31'd0, dmem_req};
         S_WE:    return {31'd0, dmem_we};
         S_ADDR:  return dmem_addr;
         S_WDATA: return dmem_wdata;
         S_BE:    return {28'd0, dmem_be};
         S_RD:    return {27'd0, rd_mem};
         S_RWM:   return {31'd0, reg_write_mem};
         S_ALU:   return alu_result_mem;
         S_LOAD:  return load_data_mem;
         S_M2R:   return {31'd0, mem_to_reg_mem};
         S_MIS:   return {31'd0, misalign_o};
`ifdef EX_MEM_PERF_EN
         S_PERF:  return stall_cycles;
`endif
         default: return 32'hxxxx_xxxx;
      endcase
   endfunction

   function automatic string sig_name(input int sel);
      case (sel)
         S_STALL: return "stall_o";
         S_REQ:   return "dmem_req";
         S_WE:    return "dmem_we";
         S_ADDR:  return "dmem_addr";
         S_WDATA: return "dmem_wdata";
         S_BE:    return "dmem_be";
         S_RD:    return "rd_mem";
         S_RWM:   return "reg_write_mem";
         S_ALU:   return "alu_result_mem";
         S_LOAD:  return "load_data_mem";
         S_M2R:   return "mem_to_reg_mem";
         S_MIS:   return "misalign_o";
         default: return "stall_cycles";
      endcase
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Monitor: compare every expectation tagged for the current cycle.
   initial forever begin
      logic [31:0] act;
      @(negedge clk);
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc == cyc) begin
            act = get_sig(sb[i].sel);
            checks++;
            if (act !== sb[i].exp) begin
               errors++;
               $display("FAIL %s cyc=%0d actual=0x%08h expected=0x%08h",
                        sig_name(sb[i].sel), cyc, act, sb[i].exp);
            end
            sb.delete(i);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic at(input int dc, input int sel, input logic [31:0] v);
      exp_t e;
      e.cyc = cyc + dc;
      e.sel = sel;
      e.exp = v;
      sb.push_back(e);
   endtask

   task automatic idle();
      ex_valid     = 1'b0;
      ex_reg_write = 1'b0;
      ex_mem_read  = 1'b0;
      ex_mem_write = 1'b0;
      flush        = 1'b0;
   endtask

   task automatic issue(input logic v, input logic [31:0] alu, input logic [31:0] sd,
                        input logic [4:0] rd, input logic rw, input logic mr,
                        input logic mw, input logic [2:0] f3, input logic fl);
      ex_valid      = v;
      ex_alu_result = alu;
      ex_store_data = sd;
      ex_rd         = rd;
      ex_reg_write  = rw;
      ex_mem_read   = mr;
      ex_mem_write  = mw;
      ex_funct3     = f3;
      flush         = fl;
   endtask

   // Memory op acknowledged in its first WAIT cycle.
   task automatic mem_op_fast(input logic [31:0] addr, input logic [31:0] sd,
                              input logic mr, input logic mw, input logic [2:0] f3,
                              input logic [31:0] rdata_v);
      issue(1'b1, addr, sd, 5'd1, mr, mr, mw, f3, 1'b0);
      dmem_rdata = rdata_v;
      step();
      idle();
      dmem_ack = 1'b1;
      step();
      dmem_ack = 1'b0;
   endtask

   initial begin
      rst_n      = 1'b0;
      dmem_ack   = 1'b0;
      dmem_rdata = 32'h0;
      issue(1'b1, 32'h55, 32'h66, 5'd5, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
      step();
      step();

      // Reset state, with a live EX bundle held on the inputs.
      at(0, S_STALL, 0); at(0, S_REQ, 0); at(0, S_WE, 0); at(0, S_BE, 0);
      at(0, S_MIS, 0); at(0, S_RWM, 0); at(0, S_ALU, 0); at(0, S_LOAD, 0);
      at(0, S_M2R, 0); at(0, S_RD, 0);
`ifdef EX_MEM_PERF_EN
      at(0, S_PERF, 0);
`endif
      step();
      idle();
      rst_n = 1'b1;
      step();

      // ALU op passes through in one cycle.
      issue(1'b1, 32'h10, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
      at(1, S_RD, 5); at(1, S_RWM, 1); at(1, S_ALU, 32'h10);
      at(1, S_STALL, 0); at(1, S_REQ, 0); at(1, S_M2R, 0);
      step();
      idle();

      // LB from 0x103, ack after two stalled WAIT cycles.
      issue(1'b1, 32'h103, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
      dmem_rdata = 32'h8012_3456;
      at(1, S_STALL, 1); at(1, S_REQ, 1); at(1, S_ADDR, 32'h100);
      at(1, S_RWM, 0); at(1, S_M2R, 1); at(1, S_WE, 0);
      at(2, S_STALL, 1); at(3, S_STALL, 0);
      at(4, S_LOAD, 32'hFFFF_FF80); at(4, S_REQ, 0);
`ifdef EX_MEM_PERF_EN
      at(4, S_PERF, 2);
`endif
      step();
      idle();
      step();
      step();
      dmem_ack = 1'b1;
      step();
      dmem_ack = 1'b0;

      // SH 0x1234 to 0x22, ack in first WAIT cycle.
      issue(1'b1, 32'h22, 32'hABCD_1234, 5'd0, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0);
      at(1, S_BE, 4'b1100); at(1, S_WDATA, 32'h1234_1234); at(1, S_ADDR, 32'h20);
      at(1, S_WE, 1); at(1, S_REQ, 1); at(1, S_STALL, 0);
      at(2, S_REQ, 0); at(2, S_WE, 0);
      step();
      idle();
      dmem_ack = 1'b1;
      step();
      dmem_ack = 1'b0;

      // Misaligned LW at 0x41.
      issue(1'b1, 32'h41, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 3'b010, 1'b0);
      at(1, S_MIS, 1); at(1, S_REQ, 0); at(1, S_RWM, 0); at(1, S_STALL, 0);
      at(2, S_MIS, 0);
      step();
      idle();
      step();

      // SW in flight; flushed ALU bundle waits behind it and captures as invalid.
      issue(1'b1, 32'h80, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 1'b1, 3'b010, 1'b0);
      at(1, S_REQ, 1); at(1, S_STALL, 1); at(1, S_BE, 4'hF);
      at(1, S_WDATA, 32'hDEAD_BEEF); at(1, S_ADDR, 32'h80);
      at(2, S_REQ, 1); at(2, S_STALL, 0); at(2, S_RD, 0);
      at(3, S_REQ, 0); at(3, S_RWM, 0); at(3, S_RD, 3); at(3, S_M2R, 0);
      step();
      issue(1'b1, 32'h77, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1);
      step();
      dmem_ack = 1'b1;
      step();
      dmem_ack = 1'b0;
      idle();

      // Sub-word loads and a byte store.
      at(1, S_REQ, 1); at(2, S_LOAD, 32'hFFFF_8001);
      mem_op_fast(32'h12, 32'h0, 1'b1, 1'b0, 3'b001, 32'h8001_5555);
      at(2, S_LOAD, 32'h0000_8001);
      mem_op_fast(32'h12, 32'h0, 1'b1, 1'b0, 3'b101, 32'h8001_5555);
      at(2, S_LOAD, 32'h0000_00F2);
      mem_op_fast(32'h101, 32'h0, 1'b1, 1'b0, 3'b100, 32'h0000_F200);
      at(1, S_BE, 4'b0010); at(1, S_WDATA, 32'hABAB_ABAB); at(1, S_ADDR, 32'h4);
      mem_op_fast(32'h5, 32'h0000_00AB, 1'b0, 1'b1, 3'b000, 32'h0);

      // Reset dropped mid-WAIT, then a stray ack after release.
      issue(1'b1, 32'h200, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 3'b010, 1'b0);
      at(1, S_REQ, 1); at(1, S_STALL, 1);
      step();
      idle();
      step();
      rst_n = 1'b0;
      at(0, S_REQ, 0); at(0, S_STALL, 0); at(0, S_LOAD, 0);
`ifdef EX_MEM_PERF_EN
      at(0, S_PERF, 0);
`endif
      step();
      rst_n      = 1'b1;
      dmem_ack   = 1'b1;
      dmem_rdata = 32'hFFFF_FFFF;
      at(0, S_STALL, 0); at(0, S_REQ, 0); at(1, S_LOAD, 0);
      step();
      dmem_ack = 1'b0;
      step();
      step();
      step();

      if (sb.size() != 0) begin
         checks += sb.size();
         errors += sb.size();
         $display("FAIL scoreboard_drain actual=%0d pending expected=0 pending", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
